// File: rtl/ie_image_loader.sv
// ie_image_loader: streams a boot image into CPU memory and holds the CPU in
// reset until the whole image has been written.
//
// Image formats (selected by mode on an accepted start):
//   dense  (0): every source word is one data byte, written from BASE_ADDR up
//   sparse (1): source words alternate address, data
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, mode         load request pulse and image format
//   src_valid/ready     source word handshake; src_data, src_last
//   mem_we/addr/wdata   memory write request, held until mem_ack
//   mem_ack             memory accepted the write (may be same cycle as mem_we)
//   cpu_hold            CPU reset hold, dropped only after a good load
//   busy, done, err     load status (done/err are sticky until next start)
//   byte_count          bytes written in the current load
//
// Optional build macro IE_LOADER_CHECKSUM_EN adds checksum / exp_checksum:
// a running modulo-2^DATA_W sum of acked bytes, compared with exp_checksum
// when the last byte is acked; a mismatch ends the load in ERROR.
module ie_image_loader #(
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned DATA_W    = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 'h0200,
  parameter int unsigned MAX_BYTES = 4096
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              mode,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [ADDR_W-1:0] src_data,
  input  logic              src_last,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] byte_count
`ifdef IE_LOADER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] checksum,
  input  logic [DATA_W-1:0] exp_checksum
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_GET_ADDR, S_GET_DATA, S_WRITE, S_DONE, S_ERROR
  } state_t;

  state_t            state_q, state_d;
  logic              mode_q, mode_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              src_ready_q, src_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_hold_q, cpu_hold_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] byte_count_q, byte_count_d;
  logic [DATA_W-1:0] checksum_q, checksum_d;

  logic              xfer;
  logic [31:0]       bc_next;
  logic [DATA_W-1:0] sum_next;
  logic              sum_ok;

  assign xfer     = src_valid && src_ready_q;
  // 32-bit count so the MAX_BYTES compare cannot alias when truncated
  assign bc_next  = 32'(byte_count_q) + 32'd1;
  assign sum_next = checksum_q + mem_wdata_q;
`ifdef IE_LOADER_CHECKSUM_EN
  assign sum_ok   = (sum_next == exp_checksum);
`else
  assign sum_ok   = 1'b1;
`endif

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    last_d       = last_q;
    cur_addr_d   = cur_addr_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_hold_d   = cpu_hold_q;
    busy_d       = busy_q;
    done_d       = done_q;
    err_d        = err_q;
    byte_count_d = byte_count_q;
    checksum_d   = checksum_q;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          mode_d       = mode;
          done_d       = 1'b0;
          err_d        = 1'b0;
          byte_count_d = '0;
          checksum_d   = '0;
          busy_d       = 1'b1;
          cpu_hold_d   = 1'b1;
          if (mode) begin
            state_d = S_GET_ADDR;
          end else begin
            cur_addr_d = BASE_ADDR;
            state_d    = S_GET_DATA;
          end
        end
      end
      S_GET_ADDR: begin
        if (xfer) begin
          // an address with nothing after it is a malformed image
          if (src_last) begin
            state_d = S_ERROR;
          end else begin
            cur_addr_d = src_data;
            state_d    = S_GET_DATA;
          end
        end
      end
      S_GET_DATA: begin
        if (xfer) begin
          mem_addr_d  = cur_addr_q;
          mem_wdata_d = src_data[DATA_W-1:0];
          last_d      = src_last;
          mem_we_d    = 1'b1;
          state_d     = S_WRITE;
        end
      end
      S_WRITE: begin
        if (mem_ack) begin
          mem_we_d     = 1'b0;
          byte_count_d = bc_next[ADDR_W-1:0];
          checksum_d   = sum_next;
          if (last_q) begin
            state_d = sum_ok ? S_DONE : S_ERROR;
          end else if ((!mode_q && cur_addr_q == '1) || bc_next == 32'(MAX_BYTES)) begin
            // dense address wrap or oversize image: abort rather than clobber
            state_d = S_ERROR;
          end else if (mode_q) begin
            state_d = S_GET_ADDR;
          end else begin
            cur_addr_d = cur_addr_q + 1'b1;
            state_d    = S_GET_DATA;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // terminal-state status is set on the transition so it shows the cycle after
    if (state_d != state_q && state_d == S_DONE) begin
      busy_d     = 1'b0;
      done_d     = 1'b1;
      cpu_hold_d = 1'b0;
    end
    if (state_d != state_q && state_d == S_ERROR) begin
      busy_d     = 1'b0;
      err_d      = 1'b1;
      cpu_hold_d = 1'b1;
    end

    src_ready_d = (state_d == S_GET_ADDR) || (state_d == S_GET_DATA);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      mode_q       <= 1'b0;
      last_q       <= 1'b0;
      cur_addr_q   <= '0;
      src_ready_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      cpu_hold_q   <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      byte_count_q <= '0;
      checksum_q   <= '0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      last_q       <= last_d;
      cur_addr_q   <= cur_addr_d;
      src_ready_q  <= src_ready_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_hold_q   <= cpu_hold_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      byte_count_q <= byte_count_d;
      checksum_q   <= checksum_d;
    end
  end

  assign src_ready  = src_ready_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign cpu_hold   = cpu_hold_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign err        = err_q;
  assign byte_count = byte_count_q;
`ifdef IE_LOADER_CHECKSUM_EN
  assign checksum   = checksum_q;
`endif

endmodule

// File: tb/tb_ie_image_loader.sv
module tb_ie_image_loader;
  localparam logic [15:0] BASE = 16'h0200;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start = 1'b0, mode = 1'b0;
  logic        src_valid = 1'b0, src_last = 1'b0;
  logic [15:0] src_data = '0;
  logic        src_ready, mem_we, cpu_hold, busy, done, err;
  logic [15:0] mem_addr, byte_count;
  logic [7:0]  mem_wdata;
  logic        mem_ack = 1'b0;

  ie_image_loader u_dut (
    .clk(clk), .rst(rst), .start(start), .mode(mode),
    .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data), .src_last(src_last),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .cpu_hold(cpu_hold), .busy(busy), .done(done), .err(err), .byte_count(byte_count)
  );

  // second instance for the top-of-memory wrap case
  logic        w_start = 1'b0, w_mode = 1'b0, w_src_valid = 1'b0, w_src_last = 1'b0;
  logic [15:0] w_src_data = '0;
  logic        w_mem_ack = 1'b1;
  logic        w_src_ready, w_mem_we, w_cpu_hold, w_busy, w_done, w_err;
  logic [15:0] w_mem_addr, w_byte_count;
  logic [7:0]  w_mem_wdata;

  ie_image_loader #(.BASE_ADDR(16'hFFFE)) u_wrap (
    .clk(clk), .rst(rst), .start(w_start), .mode(w_mode),
    .src_valid(w_src_valid), .src_ready(w_src_ready), .src_data(w_src_data), .src_last(w_src_last),
    .mem_we(w_mem_we), .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_ack(w_mem_ack),
    .cpu_hold(w_cpu_hold), .busy(w_busy), .done(w_done), .err(w_err), .byte_count(w_byte_count)
  );

  int total = 0, bad = 0;
  int cyc = 0, t0 = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // scoreboard of expected memory writes
  typedef struct packed { logic [15:0] a; logic [7:0] d; } wr_t;
  wr_t sb[$];
  wr_t e;

  // memory model: ack after ack_delay extra cycles, check hold-stable data
  int   ack_delay = 0, ack_cnt = 0, we_cnt = 0;
  logic ack_en = 1'b1;
  logic [15:0] hold_a;
  logic [7:0]  hold_d;
  always @(negedge clk) begin
    if (rst || !mem_we) begin
      mem_ack = 1'b0; ack_cnt = 0; we_cnt = 0;
    end else if (ack_en) begin
      we_cnt++;
      if (we_cnt == 1) begin
        hold_a = mem_addr; hold_d = mem_wdata;
      end else begin
        chk("we_hold_addr", {16'h0, mem_addr}, {16'h0, hold_a});
        chk("we_hold_data", {24'h0, mem_wdata}, {24'h0, hold_d});
        chk("ready_in_write", {31'h0, src_ready}, 32'h0);
      end
      if (ack_cnt == ack_delay) begin
        mem_ack = 1'b1;
        chk("we_len", we_cnt, ack_delay + 1);
        ack_cnt = 0; we_cnt = 0;
        if (sb.size() == 0) chk("unexpected_write", {16'h0, mem_addr}, 32'hFFFF_FFFF);
        else begin
          e = sb.pop_front();
          chk("wr_addr", {16'h0, mem_addr}, {16'h0, e.a});
          chk("wr_data", {24'h0, mem_wdata}, {24'h0, e.d});
        end
      end else begin
        mem_ack = 1'b0; ack_cnt++;
      end
    end
  end

  logic [15:0] w_log[$];
  always @(negedge clk) if (!rst && w_mem_we) w_log.push_back(w_mem_addr);

  task automatic do_start(input logic m);
    @(negedge clk); start = 1'b1; mode = m;
    @(posedge clk); #1; start = 1'b0; t0 = cyc;
  endtask

  task automatic send(input logic [15:0] d, input logic l);
    bit ok = 0;
    src_data = d; src_last = l; src_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (src_ready) begin ok = 1; break; end
    end
    if (!ok) chk("send_timeout", 32'h0, 32'h1);
    else begin @(posedge clk); #1; end
    src_valid = 1'b0; src_last = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit ok = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1; break; end
    end
    if (!ok) chk(name, 32'h0, 32'h1);
  endtask

  typedef struct {
    logic mode; int n; logic [3:0][15:0] w;
    int bc; logic dn; logic er; logic hd;
  } vec_t;

  function automatic vec_t mk(input logic m, input int n, input logic [15:0] a, b, c, d,
                              input int bc, input logic dn, er, hd);
    vec_t v;
    v.mode = m; v.n = n; v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
    v.bc = bc; v.dn = dn; v.er = er; v.hd = hd;
    return v;
  endfunction

  vec_t tv[7];
  logic [7:0] img19[19];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tv[0] = mk(0, 1, 16'h005A, 0, 0, 0,                   1, 1, 0, 0);
    tv[1] = mk(0, 3, 16'h0011, 16'h0022, 16'h00FF, 0,     3, 1, 0, 0);
    tv[2] = mk(1, 4, 16'h001E, 16'h00AA, 16'h001F, 16'h00BB, 2, 1, 0, 0);
    tv[3] = mk(1, 1, 16'h0100, 0, 0, 0,                   0, 0, 1, 1);
    tv[4] = mk(1, 2, 16'h0000, 16'h00FF, 0, 0,            1, 1, 0, 0);
    tv[5] = mk(1, 2, 16'h1234, 16'hABCD, 0, 0,            1, 1, 0, 0);
    tv[6] = mk(1, 3, 16'h0040, 16'h0011, 16'h0041, 0,     1, 0, 1, 1);
    img19 = '{8'hA2, 8'h00, 8'h8A, 8'h18, 8'h75, 8'h00, 8'h3C, 8'h01, 8'hFF, 8'h7E,
              8'h10, 8'h20, 8'h30, 8'h44, 8'h55, 8'h66, 8'h81, 8'h95, 8'h00};

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_src_ready", {31'h0, src_ready}, 0);
    chk("rst_mem_we",    {31'h0, mem_we}, 0);
    chk("rst_mem_addr",  {16'h0, mem_addr}, 0);
    chk("rst_mem_wdata", {24'h0, mem_wdata}, 0);
    chk("rst_cpu_hold",  {31'h0, cpu_hold}, 1);
    chk("rst_busy",      {31'h0, busy}, 0);
    chk("rst_done",      {31'h0, done}, 0);
    chk("rst_err",       {31'h0, err}, 0);
    chk("rst_byte_count", {16'h0, byte_count}, 0);

    // table-driven loads
    for (int i = 0; i < 7; i++) begin
      do_start(tv[i].mode);
      for (int j = 0; j < tv[i].n; j++) begin
        if (!tv[i].mode) sb.push_back({BASE + 16'(j), tv[i].w[j][7:0]});
        else if (j % 2 == 1) sb.push_back({tv[i].w[j-1], tv[i].w[j][7:0]});
        send(tv[i].w[j], j == tv[i].n - 1);
      end
      wait_idle("vec_timeout");
      chk($sformatf("v%0d_byte_count", i), {16'h0, byte_count}, tv[i].bc);
      chk($sformatf("v%0d_done", i), {31'h0, done}, {31'h0, tv[i].dn});
      chk($sformatf("v%0d_err", i), {31'h0, err}, {31'h0, tv[i].er});
      chk($sformatf("v%0d_cpu_hold", i), {31'h0, cpu_hold}, {31'h0, tv[i].hd});
      chk($sformatf("v%0d_sb_drain", i), sb.size(), 0);
    end

    // 19-byte dense image, ack tied high: DONE 38 cycles after start
    do_start(0);
    for (int j = 0; j < 19; j++) begin
      sb.push_back({BASE + 16'(j), img19[j]});
      send({8'h00, img19[j]}, j == 18);
    end
    begin
      bit ok = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (done) begin ok = 1; break; end
      end
      chk("d19_done_seen", {31'h0, ok}, 1);
      chk("d19_latency", cyc - t0, 38);
    end
    chk("d19_byte_count", {16'h0, byte_count}, 19);
    chk("d19_cpu_hold", {31'h0, cpu_hold}, 0);
    chk("d19_busy", {31'h0, busy}, 0);
    chk("d19_sb_drain", sb.size(), 0);

    // backpressure: 3-cycle ack delay, plus a start pulse mid-load that must be ignored
    ack_delay = 3;
    do_start(0);
    for (int j = 0; j < 4; j++) begin
      sb.push_back({BASE + 16'(j), 8'(8'hC0 + j)});
      send(16'(8'hC0 + j), j == 3);
      if (j == 0) do_start(1);
    end
    wait_idle("bp_timeout");
    chk("bp_byte_count", {16'h0, byte_count}, 4);
    chk("bp_done", {31'h0, done}, 1);
    chk("bp_sb_drain", sb.size(), 0);
    ack_delay = 0;

    // reset while a write is pending
    ack_en = 1'b0;
    do_start(0);
    send(16'h0077, 1'b0);
    begin
      bit ok = 0;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (mem_we) begin ok = 1; break; end
      end
      chk("rw_we_seen", {31'h0, ok}, 1);
    end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rw_mem_we", {31'h0, mem_we}, 0);
    chk("rw_busy", {31'h0, busy}, 0);
    chk("rw_cpu_hold", {31'h0, cpu_hold}, 1);
    chk("rw_byte_count", {16'h0, byte_count}, 0);
    sb.delete();
    w_log.delete();
    ack_en = 1'b1;
    do_start(0);
    for (int j = 0; j < 3; j++) begin
      sb.push_back({BASE + 16'(j), 8'(8'h31 + j)});
      send(16'(8'h31 + j), j == 2);
    end
    wait_idle("rw_reload_timeout");
    chk("rw_reload_done", {31'h0, done}, 1);
    chk("rw_reload_count", {16'h0, byte_count}, 3);
    chk("rw_reload_sb", sb.size(), 0);

    // dense wrap at top of memory on the second instance
    @(negedge clk); w_start = 1'b1; w_mode = 1'b0;
    @(posedge clk); #1 w_start = 1'b0;
    for (int j = 0; j < 3; j++) begin
      w_src_data = 16'(8'hE0 + j); w_src_last = (j == 2); w_src_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        if (w_src_ready || w_err) break;
      end
      if (w_src_ready) begin @(posedge clk); #1; end
      w_src_valid = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk("wrap_nwrites", w_log.size(), 2);
    if (w_log.size() >= 2) begin
      chk("wrap_addr0", {16'h0, w_log[0]}, 32'hFFFE);
      chk("wrap_addr1", {16'h0, w_log[1]}, 32'hFFFF);
    end
    chk("wrap_err", {31'h0, w_err}, 1);
    chk("wrap_done", {31'h0, w_done}, 0);
    chk("wrap_cpu_hold", {31'h0, w_cpu_hold}, 1);
    chk("wrap_byte_count", {16'h0, w_byte_count}, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/ie_image_loader.md
Name: ie_image_loader

Overview:
- Parametrised boot-image loader for the CPU/IE test environment. Generalises the fixed program and memory listings into a streamed image.
- Accepts a word stream in one of two modes:
  - dense: bytes written contiguously from BASE_ADDR
  - sparse: (address, data) pairs
- Writes each byte to CPU memory over a write/ack handshake. Holds the CPU in reset until the image is fully loaded.
- Sits between the testbench/host image source and the memory arbiter, ahead of IF.

Parameters:
- ADDR_W, 16, memory address width; also the src_data width.
- DATA_W, 8, memory data width; must be ≤ ADDR_W.
- BASE_ADDR, 16'h0200, dense-mode start address (program load origin).
- MAX_BYTES, 4096, maximum bytes per image; overflow is an error.

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  one-cycle pulse; begins a load
- mode  in  1  0=dense, 1=sparse; sampled on accepted start
- src_valid  in  1  source word valid
- src_ready  out  1  loader accepts source word
- src_data  in  ADDR_W  address word (sparse) or data in [DATA_W-1:0]
- src_last  in  1  marks final word of image
- mem_we  out  1  memory write request
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  DATA_W  write data
- mem_ack  in  1  memory accepted write (may be same cycle as mem_we)
- cpu_hold  out  1  active-high CPU reset hold
- busy  out  1  load in progress
- done  out  1  sticky, image loaded OK
- err  out  1  sticky, load aborted
- byte_count  out  ADDR_W  bytes written this load

Behaviour:
- Clock is clk. Reset is rst, synchronous, active-high.
- Reset values:
  - src_ready=0, mem_we=0, mem_addr=0, mem_wdata=0
  - cpu_hold=1, busy=0, done=0, err=0, byte_count=0
  - state=IDLE
- States: IDLE, GET_ADDR, GET_DATA, WRITE, DONE, ERROR.
- IDLE/DONE/ERROR + start:
  - Latch mode. Clear done, err and byte_count. Set busy=1 and cpu_hold=1.
  - dense: cur_addr=BASE_ADDR, go to GET_DATA.
  - sparse: go to GET_ADDR.
- start while busy is ignored.
- src_ready=1 only in GET_ADDR and GET_DATA. A transfer occurs when src_valid && src_ready.
- GET_ADDR:
  - On transfer, latch cur_addr=src_data and go to GET_DATA.
  - If src_last is set on this transfer, go to ERROR (orphan address).
- GET_DATA:
  - On transfer, mem_addr=cur_addr and mem_wdata=src_data[DATA_W-1:0].
  - Latch src_last into last_q and go to WRITE.
- WRITE:
  - mem_we=1; mem_addr and mem_wdata held stable until mem_ack.
  - On mem_ack, byte_count is incremented.
  - If last_q: next state is DONE.
  - Else dense: cur_addr+1 and go to GET_DATA. Else sparse: go to GET_ADDR.
- mem_we deasserts in the cycle after the ack.
- Throughput with mem_ack tied high:
  - dense: 2 cycles per byte.
  - sparse: 3 cycles per byte.
- DONE: busy=0, done=1, cpu_hold=0 (CPU released). Cycle-level entry timing:
  - The cycle after the last ack shows busy=0, done=1 and cpu_hold=0.
- ERROR: busy=0, err=1, cpu_hold=1 (CPU stays held). No further memory writes.
- Dense wrap:
  - If cur_addr is all-ones and the byte is acked without last_q, go to ERROR instead of wrapping.
  - No write ever occurs to address 0 by wrap.
- Overflow: if byte_count would reach MAX_BYTES on an ack without last_q, go to ERROR.
- Reset mid-load: at the reset edge all outputs return to reset values. A pending mem_we drops at that edge, and the partial image is abandoned.
- Upstream words presented while src_ready=0 are not consumed.

Optional Feature:
- Macro IE_LOADER_CHECKSUM_EN.
- When defined:
  - Adds output checksum[DATA_W-1:0], reset/cleared-on-start to 0.
  - Running modulo-2^DATA_W sum of every acked mem_wdata.
  - Adds input exp_checksum[DATA_W-1:0], sampled on entry to DONE. On mismatch the loader enters ERROR instead of DONE: err=1, cpu_hold stays 1.
- When undefined: no checksum logic or ports; last ack always goes to DONE.

Test Plan:
- Dense, mode=0, 19-byte stream A2 00 8A 18 75 00 … 95 00, last on final byte, mem_ack tied 1 -> writes 0x0200..0x0212, byte_count=19. DONE is reached 38 cycles after start. Then done=1 and cpu_hold=0.
- Sparse, words 001E,00AA,001F,00BB (last on 00BB) -> two writes: [001E]=AA and [001F]=BB. byte_count=2, done=1.
- Backpressure: dense, mem_ack delayed 3 cycles per write -> mem_we stays high 4 cycles with stable addr/data. src_ready stays 0 during WRITE. No byte lost or duplicated.
- Orphan address: sparse, first word 0x0100 with src_last=1 -> no write, err=1, cpu_hold=1, done=0.
- Wrap: BASE_ADDR=16'hFFFE, dense 3 bytes -> writes at FFFE and FFFF. The third byte is not written, err=1.
- rst pulse while in WRITE with mem_ack low -> next cycle mem_we=0, busy=0, cpu_hold=1. A subsequent start performs a clean full load.
